// File: rtl/dc_ctrl_pkg.sv
// Shared state encoding, default widths and window-size clamp for the DC-error window controller.
package dc_ctrl_pkg;
  localparam int DEF_DATA_WIDTH      = 18;
  localparam int DEF_ACC_DATA_WIDTH  = 36;
  localparam int DEF_LOG2_WINDOW_MAX = 18;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    PRIME = ST_PRIME,
    RUN   = ST_RUN
  } state_t;

  function automatic logic [4:0] clamp_log2(input logic [4:0] k, input logic [4:0] kmax);
    return (k > kmax) ? kmax : k;
  endfunction
endpackage

// File: rtl/dc_avg_scaler.sv
// Window sum to per-symbol DC estimate: arithmetic right shift by K, saturated to DATA_WIDTH signed.
module dc_avg_scaler #(
  parameter int DATA_WIDTH     = 18,
  parameter int ACC_DATA_WIDTH = 36
) (
  input  logic signed [ACC_DATA_WIDTH-1:0] acc,
  input  logic        [4:0]                shift,
  output logic signed [DATA_WIDTH-1:0]     est
);
  localparam logic signed [ACC_DATA_WIDTH-1:0] MAXV =
    {{(ACC_DATA_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_DATA_WIDTH-1:0] MINV =
    {{(ACC_DATA_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [ACC_DATA_WIDTH-1:0] sh;
  assign sh = acc >>> shift;

  always_comb begin
    est = sh[DATA_WIDTH-1:0];
    if (sh > MAXV)      est = MAXV[DATA_WIDTH-1:0];
    else if (sh < MINV) est = MINV[DATA_WIDTH-1:0];
  end
endmodule

// File: rtl/dc_error_window_ctrl.sv
// Sequences the DC-error accumulator over 2^K-symbol windows; the optional per-symbol
// DC estimate output is built when DC_AVG_OUT_EN is defined.
module dc_error_window_ctrl
  import dc_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int ACC_DATA_WIDTH  = DEF_ACC_DATA_WIDTH,
  parameter int LOG2_WINDOW_MAX = DEF_LOG2_WINDOW_MAX,
  parameter int CNT_WIDTH       = LOG2_WINDOW_MAX + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sym_clk_ena,
  input  logic                 enable,
  input  logic [4:0]           window_log2,
  output logic                 clear_accumulator,
  output logic [CNT_WIDTH-1:0] sym_count,
  output logic                 window_done,
  output logic [15:0]          windows_completed
`ifdef DC_AVG_OUT_EN
  ,
  input  logic [ACC_DATA_WIDTH-1:0] acc_error_out,
  output logic [DATA_WIDTH-1:0]     dc_estimate,
  output logic                      dc_valid
`endif
);
  localparam logic [4:0] KMAX = 5'(LOG2_WINDOW_MAX);

  if (ACC_DATA_WIDTH < DATA_WIDTH + LOG2_WINDOW_MAX) begin : g_width_chk
    $error("ACC_DATA_WIDTH too small for DATA_WIDTH + LOG2_WINDOW_MAX");
  end

  state_t               state, state_nxt;
  logic [4:0]           k_cur;
  logic [CNT_WIDTH-1:0] win_n;
  logic                 terminal;

  assign win_n    = CNT_WIDTH'(1) << k_cur;
  assign terminal = (sym_count == win_n);

  // Dropping enable overrides everything, including a terminal strobe.
  always_comb begin
    state_nxt         = state;
    clear_accumulator = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  state_nxt = PRIME;
        PRIME: if (sym_clk_ena) begin
                 clear_accumulator = 1'b1;
                 state_nxt         = RUN;
               end
        RUN:   if (sym_clk_ena && terminal) clear_accumulator = 1'b1;
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef DC_AVG_OUT_EN
  logic [4:0]                  k_last;
  logic signed [DATA_WIDTH-1:0] scaled;

  dc_avg_scaler #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ACC_DATA_WIDTH(ACC_DATA_WIDTH)
  ) u_scaler (
    .acc  (acc_error_out),
    .shift(k_last),
    .est  (scaled)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dc_estimate <= '0;
      dc_valid    <= 1'b0;
    end else begin
      if (window_done) dc_estimate <= scaled;
      dc_valid <= window_done;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      k_cur             <= '0;
      sym_count         <= '0;
      window_done       <= 1'b0;
      windows_completed <= '0;
`ifdef DC_AVG_OUT_EN
      k_last            <= '0;
`endif
    end else begin
      state       <= state_nxt;
      window_done <= 1'b0;
      if (!enable) begin
        sym_count <= '0;
      end else if (sym_clk_ena && state == PRIME) begin
        sym_count <= CNT_WIDTH'(1);
        k_cur     <= clamp_log2(window_log2, KMAX);
      end else if (sym_clk_ena && state == RUN) begin
        if (terminal) begin
          sym_count         <= CNT_WIDTH'(1);
          k_cur             <= clamp_log2(window_log2, KMAX);
          window_done       <= 1'b1;
          windows_completed <= windows_completed + 16'd1;
`ifdef DC_AVG_OUT_EN
          k_last            <= k_cur;
`endif
        end else begin
          sym_count <= sym_count + CNT_WIDTH'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_dc_error_window_ctrl.sv
// Bench for dc_error_window_ctrl: directed scenarios plus randomized traffic against a window-level model.
module tb_dc_error_window_ctrl;
  localparam int DW = 18;
  localparam int AW = 36;
  localparam int KM = 18;
  localparam int CW = KM + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          sym_clk_ena;
  logic          enable;
  logic [4:0]    window_log2;
  logic          clear_accumulator;
  logic [CW-1:0] sym_count;
  logic          window_done;
  logic [15:0]   windows_completed;
  logic [AW-1:0] acc_error_out;
`ifdef DC_AVG_OUT_EN
  logic [DW-1:0] dc_estimate;
  logic          dc_valid;
`endif

  dc_error_window_ctrl dut (
    .clk              (clk),
    .reset            (rst),
    .sym_clk_ena      (sym_clk_ena),
    .enable           (enable),
    .window_log2      (window_log2),
    .clear_accumulator(clear_accumulator),
    .sym_count        (sym_count),
    .window_done      (window_done),
    .windows_completed(windows_completed)
`ifdef DC_AVG_OUT_EN
    ,
    .acc_error_out    (acc_error_out),
    .dc_estimate      (dc_estimate),
    .dc_valid         (dc_valid)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_clr  = 0;
  int n_done = 0;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Window-level model: phase 0 = disabled, 1 = waiting for the flush strobe, 2 = counting a window.
  int      m_phase, m_cnt, m_kc, m_kl, m_wc;
  bit      m_done, m_val;
  longint  m_est;
  bit      p_done;
  int      p_kl;

  function automatic int kclamp(input int w);
    return (w > KM) ? KM : w;
  endfunction

  function automatic longint sat(input longint v);
    longint hi = (longint'(1) <<< (DW-1)) - 1;
    longint lo = -(longint'(1) <<< (DW-1));
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_kc = 0; m_kl = 0; m_wc = 0;
      m_done = 0; m_val = 0; m_est = 0;
    end else begin
      p_done = m_done;
      p_kl   = m_kl;
      m_done = 0;
      if (!enable) begin
        m_phase = 0;
        m_cnt   = 0;
      end else if (m_phase == 0) begin
        m_phase = 1;
      end else if (sym_clk_ena) begin
        if (m_phase == 1) begin
          m_phase = 2; m_cnt = 1; m_kc = kclamp(int'(window_log2));
        end else if (m_cnt == (1 << m_kc)) begin
          m_kl = m_kc; m_cnt = 1; m_kc = kclamp(int'(window_log2));
          m_done = 1; m_wc = (m_wc + 1) % 65536;
        end else begin
          m_cnt++;
        end
      end
      if (p_done) m_est = sat(longint'($signed(acc_error_out)) >>> p_kl);
      m_val = p_done;
    end
  end

  always @(negedge clk) begin
    bit exp_clr;
    exp_clr = enable && sym_clk_ena && (m_phase == 1 || (m_phase == 2 && m_cnt == (1 << m_kc)));
    chk("clear_accumulator", 64'(clear_accumulator), 64'(exp_clr));
    chk("sym_count", 64'(sym_count), 64'(m_cnt));
    chk("window_done", 64'(window_done), 64'(m_done));
    chk("windows_completed", 64'(windows_completed), 64'(m_wc));
`ifdef DC_AVG_OUT_EN
    chk("dc_valid", 64'(dc_valid), 64'(m_val));
    chk("dc_estimate", 64'($signed(dc_estimate)), m_est);
`endif
    if (clear_accumulator === 1'b1) n_clr++;
    if (window_done === 1'b1) n_done++;
  end

  task automatic cyc(input bit s);
    sym_clk_ena = s;
    @(posedge clk);
    #1;
  endtask

  task automatic strobes(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1);
      for (int j = 0; j < gap; j++) cyc(1'b0);
    end
  endtask

  int c0, d0;

  initial begin
    rst = 1'b1; sym_clk_ena = 1'b0; enable = 1'b0; window_log2 = 5'd0; acc_error_out = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sym_count", 64'(sym_count), 0);
    chk("rst_window_done", 64'(window_done), 0);
    chk("rst_windows_completed", 64'(windows_completed), 0);
    rst = 1'b0;

    // reset while counting, sym_count at 5
    enable = 1'b1; window_log2 = 5'd3;
    cyc(1'b0);
    strobes(5, 0);
    chk("t1_sym_count", 64'(sym_count), 5);
    chk("t1_model_cnt", 64'(m_cnt), 5);
    sym_clk_ena = 1'b1; rst = 1'b1;
    #1;
    chk("t1_rst_clear", 64'(clear_accumulator), 0);
    chk("t1_rst_sym_count", 64'(sym_count), 0);
    chk("t1_rst_done", 64'(window_done), 0);
    @(posedge clk); #1;
    rst = 1'b0; enable = 1'b0;
    cyc(1'b0);

    // K=2, strobe every 4 clocks
    c0 = n_clr; d0 = n_done;
    enable = 1'b1; window_log2 = 5'd2;
    cyc(1'b0);
    strobes(13, 3);
    chk("t2_clears", 64'(n_clr - c0), 4);
    chk("t2_dones", 64'(n_done - d0), 3);
    chk("t2_windows_completed", 64'(windows_completed), 3);
    chk("t2_model_wc", 64'(m_wc), 3);
    enable = 1'b0; cyc(1'b0);

    // K=0: every strobe after the flush closes a window
    c0 = n_clr; d0 = n_done;
    enable = 1'b1; window_log2 = 5'd0;
    cyc(1'b0);
    strobes(6, 1);
    chk("t3_clears", 64'(n_clr - c0), 6);
    chk("t3_dones", 64'(n_done - d0), 5);
    chk("t3_sym_count", 64'(sym_count), 1);
    enable = 1'b0; cyc(1'b0);

    // K=3, change to K=1 mid-window
    d0 = n_done;
    enable = 1'b1; window_log2 = 5'd3;
    cyc(1'b0);
    strobes(4, 0);
    window_log2 = 5'd1;
    strobes(4, 0);
    chk("t4_sym_count8", 64'(sym_count), 8);
    chk("t4_no_done_yet", 64'(n_done - d0), 0);
    strobes(1, 1);
    chk("t4_first_close", 64'(n_done - d0), 1);
    strobes(2, 1);
    chk("t4_second_close", 64'(n_done - d0), 2);
    enable = 1'b0; cyc(1'b0);

    // disable on the terminal strobe
    c0 = n_clr; d0 = n_done;
    enable = 1'b1; window_log2 = 5'd1;
    cyc(1'b0);
    strobes(2, 0);
    enable = 1'b0; sym_clk_ena = 1'b1;
    #1;
    chk("t5_no_clear", 64'(clear_accumulator), 0);
    @(posedge clk); #1;
    cyc(1'b0);
    chk("t5_no_done", 64'(n_done - d0), 0);
    chk("t5_sym_count", 64'(sym_count), 0);
    chk("t5_clears", 64'(n_clr - c0), 1);

`ifdef DC_AVG_OUT_EN
    // K=4, constant -100 per sample: latched sum -1600
    enable = 1'b1; window_log2 = 5'd4; acc_error_out = AW'(-1600);
    cyc(1'b0);
    strobes(17, 0);
    chk("t6_done", 64'(window_done), 1);
    chk("t6_valid_lag", 64'(dc_valid), 0);
    cyc(1'b0);
    chk("t6_valid", 64'(dc_valid), 1);
    chk("t6_estimate", 64'($signed(dc_estimate)), -100);
    cyc(1'b0);
    chk("t6_valid_pulse", 64'(dc_valid), 0);
    enable = 1'b0; cyc(1'b0);
    enable = 1'b1; window_log2 = 5'd1; acc_error_out = 36'h7FFFFFF;
    cyc(1'b0);
    strobes(3, 2);
    chk("t6_saturate", 64'($signed(dc_estimate)), 131071);
    enable = 1'b0; cyc(1'b0);
`endif

    // randomized traffic
    enable = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      if ($urandom_range(0, 59) == 0)
        window_log2 = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      acc_error_out = ($urandom_range(0, 1) == 0) ? AW'($signed(18'($urandom())))
                                                  : AW'({$urandom(), $urandom()});
      rst = ($urandom_range(0, 999) == 0);
      cyc($urandom_range(0, 2) == 0);
      rst = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
